// File: rtl/axis_fringe_pkg.sv
// Shared types and helpers for the AXI4-Stream fringe counter.
package axis_fringe_pkg;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    LOW     = 2'd1,
    HIGH    = 2'd2
  } hyst_state_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_BWD  = 2'd2,
    STEP_ERR  = 2'd3
  } quad_step_t;

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  // Successor of a {b,a} level pair along the gray sequence 00->01->11->10->00.
  function automatic logic [1:0] gray_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  // Classifies the move from prev to curr; both bits flipping is ambiguous.
  function automatic quad_step_t quad_decode(input logic [1:0] prev, input logic [1:0] curr);
    quad_step_t s;
    if (curr == prev) begin
      s = STEP_NONE;
    end else if ((prev ^ curr) == 2'b11) begin
      s = STEP_ERR;
    end else if (curr == gray_next(prev)) begin
      s = STEP_FWD;
    end else begin
      s = STEP_BWD;
    end
    return s;
  endfunction

endpackage

// File: rtl/axis_fringe_counter_hyst.sv
// Per-channel hysteresis comparator producing a three-state digital level.
module hysteresis_comparator
  import axis_fringe_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] lower_i,
  input  logic signed [WIDTH-1:0] upper_i,
  output hyst_state_t             state_o,
  // Post-update level, so the decoder can act on the same edge.
  output hyst_state_t             next_o
);

  hyst_state_t state_q, state_d;

  // Next level: move only on an enabled sample with a sane threshold window.
  always_comb begin
    state_d = state_q;
    if (en_i && (lower_i < upper_i)) begin
      case (state_q)
        UNKNOWN: begin
          if (x_i >= upper_i) begin
            state_d = HIGH;
          end else if (x_i <= lower_i) begin
            state_d = LOW;
          end
        end
        LOW:     if (x_i >= upper_i) state_d = HIGH;
        HIGH:    if (x_i <= lower_i) state_d = LOW;
        default: state_d = UNKNOWN;
      endcase
    end
  end

  // Level register with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= UNKNOWN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign next_o  = state_d;

endmodule

// File: rtl/axis_fringe_counter.sv
// Quadrature fringe counter on an I/Q AXI4-Stream, emitting the running count.
module axis_fringe_counter
  import axis_fringe_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH      = 32
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] lower_threshold,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] upper_threshold,
  input  logic                                clear,
  input  logic                                S_AXIS_tvalid,
  input  logic        [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
  output logic                                S_AXIS_tready,
  output logic                                M_AXIS_tvalid,
  output logic        [COUNT_WIDTH-1:0]        M_AXIS_tdata,
  input  logic                                M_AXIS_tready,
  output logic        [15:0]                   error_count,
  output logic        [1:0]                    quad_state
);

  localparam int unsigned HalfW = AXIS_TDATA_WIDTH / 2;

  logic signed [HalfW-1:0] signal_a, signal_b;
  logic                    accept;
  hyst_state_t             a_q, b_q, a_next, b_next;

  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [15:0]             err_q, err_d;
  logic [1:0]              ref_q, ref_d;
  logic                    ref_valid_q, ref_valid_d;
  logic                    m_valid_q, m_valid_d;
  logic [COUNT_WIDTH-1:0]  m_data_q, m_data_d;

  logic                    known_next;
  logic [1:0]              curr_lvl;
  quad_step_t              step;

  assign signal_a = S_AXIS_tdata[HalfW-1:0];
  assign signal_b = S_AXIS_tdata[AXIS_TDATA_WIDTH-1:HalfW];

  assign S_AXIS_tready = aresetn & (~m_valid_q | M_AXIS_tready);
  assign accept        = S_AXIS_tvalid & S_AXIS_tready;

  hysteresis_comparator #(
    .WIDTH(HalfW)
  ) u_cmp_a (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en_i    (accept),
    .x_i     (signal_a),
    .lower_i (lower_threshold),
    .upper_i (upper_threshold),
    .state_o (a_q),
    .next_o  (a_next)
  );

  hysteresis_comparator #(
    .WIDTH(HalfW)
  ) u_cmp_b (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en_i    (accept),
    .x_i     (signal_b),
    .lower_i (lower_threshold),
    .upper_i (upper_threshold),
    .state_o (b_q),
    .next_o  (b_next)
  );

  assign known_next = (a_next != UNKNOWN) && (b_next != UNKNOWN);
  assign curr_lvl   = {b_next == HIGH, a_next == HIGH};
  assign step       = quad_decode(ref_q, curr_lvl);

  // Decode, count update, clear override and output-register next state.
  always_comb begin
    count_d     = count_q;
    err_d       = err_q;
    ref_d       = ref_q;
    ref_valid_d = ref_valid_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;

    if (accept && known_next) begin
      ref_d       = curr_lvl;
      ref_valid_d = 1'b1;
      // The first fully-known sample only establishes the reference.
      if (ref_valid_q) begin
        unique case (step)
          STEP_FWD:  count_d = count_q + COUNT_WIDTH'(1);
          STEP_BWD:  count_d = count_q - COUNT_WIDTH'(1);
          STEP_ERR:  if (err_q != ERR_MAX) err_d = err_q + 16'd1;
          STEP_NONE: ;
        endcase
      end
    end

    if (clear) begin
      count_d = '0;
      err_d   = '0;
    end

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = count_d;
    end else if (M_AXIS_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // State registers; reset also discards any pending output beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count_q     <= '0;
      err_q       <= '0;
      ref_q       <= 2'b00;
      ref_valid_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
    end else begin
      count_q     <= count_d;
      err_q       <= err_d;
      ref_q       <= ref_d;
      ref_valid_q <= ref_valid_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
    end
  end

  assign M_AXIS_tvalid = m_valid_q;
  assign M_AXIS_tdata  = m_data_q;
  assign error_count   = err_q;
  assign quad_state    = ((a_q != UNKNOWN) && (b_q != UNKNOWN)) ? {b_q == HIGH, a_q == HIGH}
                                                                : 2'b00;

endmodule

// File: tb/tb_axis_fringe_counter.sv
// Self-checking bench: behavioural model feeding an output scoreboard, plus a vector table.
module tb_axis_fringe_counter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] lower_threshold = 16'h7FFF;
  logic [15:0] upper_threshold = 16'h8000;
  logic        clear = 1'b0;
  logic        S_AXIS_tvalid = 1'b0;
  logic [31:0] S_AXIS_tdata = '0;
  logic        S_AXIS_tready;
  logic        M_AXIS_tvalid;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tready = 1'b1;
  logic [15:0] error_count;
  logic [1:0]  quad_state;

  axis_fringe_counter #(
    .AXIS_TDATA_WIDTH(32),
    .COUNT_WIDTH     (32)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .lower_threshold (lower_threshold),
    .upper_threshold (upper_threshold),
    .clear           (clear),
    .S_AXIS_tvalid   (S_AXIS_tvalid),
    .S_AXIS_tdata    (S_AXIS_tdata),
    .S_AXIS_tready   (S_AXIS_tready),
    .M_AXIS_tvalid   (M_AXIS_tvalid),
    .M_AXIS_tdata    (M_AXIS_tdata),
    .M_AXIS_tready   (M_AXIS_tready),
    .error_count     (error_count),
    .quad_state      (quad_state)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Model state: levels 0=unknown 1=low 2=high.
  int          m_a, m_b;
  int          m_lo, m_hi;
  bit [1:0]    m_ref;
  bit          m_refv;
  logic [31:0] m_cnt;
  int          m_err;
  bit          m_mv;
  bit          last_acc;
  logic [31:0] sb[$];

  typedef struct {
    int          a;
    int          b;
    bit          clr;
    logic [31:0] cnt;
    int          err;
  } vec_t;
  vec_t tv[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int hyst(input int st, input int x);
    if (m_lo >= m_hi) return st;
    if (st != 2 && x >= m_hi) return 2;
    if (st != 1 && x <= m_lo) return 1;
    return st;
  endfunction

  // Position along the forward gray cycle 00,01,11,10.
  function automatic int gpos(input bit [1:0] l);
    case (l)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] m_quad();
    if (m_a == 0 || m_b == 0) return 2'b00;
    return {m_b == 2, m_a == 2};
  endfunction

  task automatic set_thr(input int lo, input int hi);
    lower_threshold = 16'(lo);
    upper_threshold = 16'(hi);
    m_lo = lo;
    m_hi = hi;
  endtask

  // One clock: entered just after a negedge, leaves just after the next negedge.
  task automatic step(input bit v, input int a, input int b, input bit clr, input bit mr);
    bit       exp_rdy;
    bit       acc;
    bit [1:0] cur;
    int       d;
    S_AXIS_tvalid = v;
    S_AXIS_tdata  = {16'(b), 16'(a)};
    clear         = clr;
    M_AXIS_tready = mr;
    #1;
    exp_rdy = !m_mv || mr;
    chk("s_tready", 32'(S_AXIS_tready), 32'(exp_rdy));
    chk("m_tvalid", 32'(M_AXIS_tvalid), 32'(m_mv));
    if (m_mv) begin
      if (sb.size() == 0) chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      else chk("m_tdata", M_AXIS_tdata, sb[0]);
    end
    chk("error_count", 32'(error_count), 32'(m_err));
    chk("quad_state", 32'(quad_state), 32'(m_quad()));
    if (m_mv && mr && sb.size() != 0) void'(sb.pop_front());

    acc      = v && exp_rdy;
    last_acc = acc;
    if (acc) begin
      m_a = hyst(m_a, a);
      m_b = hyst(m_b, b);
      if (m_a != 0 && m_b != 0) begin
        cur = {m_b == 2, m_a == 2};
        if (m_refv) begin
          d = (gpos(cur) - gpos(m_ref)) & 3;
          if (d == 1) m_cnt = m_cnt + 32'd1;
          else if (d == 3) m_cnt = m_cnt - 32'd1;
          else if (d == 2 && m_err < 65535) m_err++;
        end
        m_ref  = cur;
        m_refv = 1'b1;
      end
    end
    if (clr) begin
      m_cnt = '0;
      m_err = 0;
    end
    if (acc) begin
      sb.push_back(m_cnt);
      m_mv = 1'b1;
    end else if (mr) begin
      m_mv = 1'b0;
    end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    S_AXIS_tvalid = 1'b0;
    clear         = 1'b0;
    #1;
    chk("rst_s_tready", 32'(S_AXIS_tready), 32'd0);
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    chk("rst_m_tdata", M_AXIS_tdata, 32'd0);
    chk("rst_error_count", 32'(error_count), 32'd0);
    chk("rst_quad_state", 32'(quad_state), 32'd0);
    m_a = 0; m_b = 0; m_ref = 2'b00; m_refv = 1'b0;
    m_cnt = '0; m_err = 0; m_mv = 1'b0;
    sb.delete();
    aresetn = 1'b1;
  endtask

  // Forward gray order as (a,b) amplitudes: 00,01,11,10 on {b,a}.
  int seq_a[4] = '{-200, 200, 200, -200};
  int seq_b[4] = '{-200, -200, 200, 200};

  initial begin
    int idx;
    int acc_stall;

    tv[0]  = '{-200, -200, 1'b0, 32'd0, 0};
    tv[1]  = '{200, -200, 1'b0, 32'd1, 0};
    tv[2]  = '{200, 200, 1'b0, 32'd2, 0};
    tv[3]  = '{-200, 200, 1'b0, 32'd3, 0};
    tv[4]  = '{-200, -200, 1'b0, 32'd4, 0};
    tv[5]  = '{-200, -200, 1'b1, 32'd0, 0};
    tv[6]  = '{-200, 200, 1'b0, 32'hFFFF_FFFF, 0};
    tv[7]  = '{200, 200, 1'b0, 32'hFFFF_FFFE, 0};
    tv[8]  = '{200, -200, 1'b0, 32'hFFFF_FFFD, 0};
    tv[9]  = '{-200, -200, 1'b0, 32'hFFFF_FFFC, 0};
    tv[10] = '{150, -200, 1'b0, 32'hFFFF_FFFD, 0};
    tv[11] = '{50, -200, 1'b0, 32'hFFFF_FFFD, 0};
    tv[12] = '{0, -200, 1'b0, 32'hFFFF_FFFD, 0};
    tv[13] = '{-99, -200, 1'b0, 32'hFFFF_FFFD, 0};
    tv[14] = '{-100, -200, 1'b0, 32'hFFFF_FFFC, 0};
    tv[15] = '{200, 200, 1'b0, 32'hFFFF_FFFC, 1};
    tv[16] = '{200, 200, 1'b1, 32'd0, 0};

    @(negedge aclk);
    set_thr(32767, -32768);
    do_reset();

    // Invalid threshold window: comparators must never leave UNKNOWN.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, $signed(16'($urandom)), $signed(16'($urandom)), 1'b0, 1'b1);
      chk("inv_quad_state", 32'(quad_state), 32'd0);
      chk("inv_m_tdata", M_AXIS_tdata, 32'd0);
    end
    step(1'b0, 0, 0, 1'b0, 1'b1);

    set_thr(-100, 100);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, tv[i].a, tv[i].b, tv[i].clr, 1'b1);
      chk($sformatf("vec%0d_tdata", i), M_AXIS_tdata, tv[i].cnt);
      chk($sformatf("vec%0d_err", i), 32'(error_count), 32'(tv[i].err));
    end

    // Step to 10 for a nonzero count, then hammer 01<->10 jumps into saturation.
    step(1'b1, -200, 200, 1'b0, 1'b1);
    chk("pre_sat_tdata", M_AXIS_tdata, 32'd1);
    for (int i = 0; i < 65536; i++) begin
      if (i % 2 == 0) step(1'b1, 200, -200, 1'b0, 1'b1);
      else step(1'b1, -200, 200, 1'b0, 1'b1);
    end
    chk("sat_error_count", 32'(error_count), 32'hFFFF);
    step(1'b1, 200, -200, 1'b0, 1'b1);
    chk("sat_hold_error_count", 32'(error_count), 32'hFFFF);
    step(1'b0, 0, 0, 1'b1, 1'b1);
    chk("clr_error_count", 32'(error_count), 32'd0);
    step(1'b1, 200, -200, 1'b0, 1'b1);
    chk("clr_count", M_AXIS_tdata, 32'd0);
    step(1'b0, 0, 0, 1'b0, 1'b1);

    // Backpressure: state is 01, so the forward sequence continues at 11.
    idx = 2;
    acc_stall = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, seq_a[idx % 4], seq_b[idx % 4], 1'b0, 1'b0);
      if (last_acc) begin
        idx++;
        acc_stall++;
      end
      chk("stall_tdata", M_AXIS_tdata, 32'd1);
    end
    chk("stall_accepts", 32'(acc_stall), 32'd1);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, seq_a[idx % 4], seq_b[idx % 4], 1'b0, 1'b1);
      if (last_acc) idx++;
    end
    step(1'b0, 0, 0, 1'b0, 1'b1);
    chk("bp_accepted", 32'(idx - 2), 32'd9);
    chk("bp_final_tdata", M_AXIS_tdata, 32'd9);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Reset with a beat pending discards it.
    step(1'b1, seq_a[idx % 4], seq_b[idx % 4], 1'b0, 1'b0);
    do_reset();
    step(1'b0, 0, 0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
